// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch stage: drives the ROM address and registers the
// returned word for decode, with start/halt control, branching, stall/squash and a fetch counter.
module fetch_unit #(
    parameter int A    = 10,
    parameter int W    = 9,
    parameter int OFFW = 6,
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [A-1:0]    StartAddr,
    input  logic            Halt,
    input  logic            Stall,
    input  logic            BranchAbs,
    input  logic            BranchRelEn,
    input  logic            Taken,
    input  logic [A-1:0]    Target,
    input  logic [OFFW-1:0] Offset,
    input  logic [W-1:0]    InstIn,
    output logic [A-1:0]    ProgCtr,
    output logic [W-1:0]    Inst,
    output logic            InstValid,
    output logic            Running,
    output logic            Done,
    output logic [CNTW-1:0] FetchCnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]      state_q,   state_d;
    logic [A-1:0]    pc_q,      pc_d;
    logic [W-1:0]    inst_q,    inst_d;
    logic            valid_q,   valid_d;
    logic            running_q, running_d;
    logic            done_q,    done_d;
    logic [CNTW-1:0] cnt_q,     cnt_d;

    logic [A-1:0]    offset_ext;
    logic            rel_taken;

    assign offset_ext = {{(A-OFFW){Offset[OFFW-1]}}, Offset};
    assign rel_taken  = BranchRelEn & Taken;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                valid_d = 1'b0;
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    // The word at the current PC is always captured; a taken redirect only squashes it.
                    inst_d = InstIn;
                    if (BranchAbs) begin
                        pc_d    = Target;
                        valid_d = 1'b0;
                    end else if (rel_taken) begin
                        pc_d    = pc_q + offset_ext;
                        valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + A'(1);
                        valid_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
            running_q <= running_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ProgCtr   = pc_q;
    assign Inst      = inst_q;
    assign InstValid = valid_q;
    assign Running   = running_q;
    assign Done      = done_q;
    assign FetchCnt  = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a reference model queues expected outputs per cycle,
// compared after each edge, plus fixed-value checks for the key scenarios.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst, start, halt, stall, br_abs, br_rel, taken;
    logic [9:0] start_addr, target;
    logic [5:0] offset;
    logic [8:0] inst_in, sat_inst_in;
    logic [9:0] prog_ctr, sat_pc;
    logic [8:0] inst, sat_inst;
    logic       inst_valid, running, done;
    logic       sat_valid, sat_running, sat_done;
    logic [15:0] fetch_cnt;
    logic [2:0]  sat_cnt;

    logic [8:0] rom_mem [0:1023];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  pc;
        logic [8:0]  inst;
        logic        valid;
        logic        running;
        logic        done;
        logic [15:0] cnt;
        logic        chk_inst;
        string       tag;
    } exp_t;

    exp_t sb[$];

    int          m_state = 0;
    logic [9:0]  m_pc    = '0;
    logic [8:0]  m_inst  = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt   = '0;

    always #5 clk = ~clk;

    assign inst_in     = rom_mem[prog_ctr];
    assign sat_inst_in = rom_mem[sat_pc];

    fetch_unit #(.A(10), .W(9), .OFFW(6), .CNTW(16)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .StartAddr(start_addr), .Halt(halt),
        .Stall(stall), .BranchAbs(br_abs), .BranchRelEn(br_rel), .Taken(taken),
        .Target(target), .Offset(offset), .InstIn(inst_in), .ProgCtr(prog_ctr),
        .Inst(inst), .InstValid(inst_valid), .Running(running), .Done(done),
        .FetchCnt(fetch_cnt)
    );

    fetch_unit #(.A(10), .W(9), .OFFW(6), .CNTW(3)) dut_sat (
        .Clk(clk), .Reset(rst), .Start(start), .StartAddr(start_addr), .Halt(halt),
        .Stall(stall), .BranchAbs(br_abs), .BranchRelEn(br_rel), .Taken(taken),
        .Target(target), .Offset(offset), .InstIn(sat_inst_in), .ProgCtr(sat_pc),
        .Inst(sat_inst), .InstValid(sat_valid), .Running(sat_running), .Done(sat_done),
        .FetchCnt(sat_cnt)
    );

    task automatic clear_inputs();
        rst = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
        br_abs = 1'b0; br_rel = 1'b0; taken = 1'b0;
        start_addr = '0; target = '0; offset = '0;
    endtask

    // One clock: advance the model with the inputs now applied, queue the expectation,
    // then compare it against the DUT just after the edge.
    task automatic cycle(input string tag);
        exp_t e;
        exp_t g;
        e.chk_inst = 1'b1;
        if (rst) begin
            m_state = 0; m_pc = '0; m_inst = '0; m_valid = 1'b0; m_cnt = '0;
        end else if (m_state != 1) begin
            m_valid = 1'b0;
            if (start) begin
                m_state = 1; m_pc = start_addr; m_cnt = '0;
            end
        end else if (halt) begin
            m_state = 2; m_valid = 1'b0; e.chk_inst = 1'b0;
        end else if (!stall) begin
            m_inst = rom_mem[m_pc];
            if (br_abs) begin
                m_pc = target; m_valid = 1'b0;
            end else if (br_rel && taken) begin
                m_pc = m_pc + {{4{offset[5]}}, offset}; m_valid = 1'b0;
            end else begin
                m_pc = m_pc + 10'd1; m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        e.pc = m_pc; e.inst = m_inst; e.valid = m_valid; e.cnt = m_cnt;
        e.running = (m_state == 1); e.done = (m_state == 2); e.tag = tag;
        sb.push_back(e);

        @(posedge clk);
        #1;
        g = sb.pop_front();
        total++;
        if (prog_ctr !== g.pc) begin
            bad++; $display("FAIL %s pc: got %h want %h", g.tag, prog_ctr, g.pc);
        end
        if (g.chk_inst) begin
            total++;
            if (inst !== g.inst) begin
                bad++; $display("FAIL %s inst: got %h want %h", g.tag, inst, g.inst);
            end
        end
        total++;
        if (inst_valid !== g.valid) begin
            bad++; $display("FAIL %s valid: got %b want %b", g.tag, inst_valid, g.valid);
        end
        total++;
        if (running !== g.running || done !== g.done) begin
            bad++; $display("FAIL %s state: got run=%b done=%b want run=%b done=%b",
                            g.tag, running, done, g.running, g.done);
        end
        total++;
        if (fetch_cnt !== g.cnt) begin
            bad++; $display("FAIL %s cnt: got %0d want %0d", g.tag, fetch_cnt, g.cnt);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        cycle("rst_a");
        cycle("rst_b");
        rst = 1'b0;
        start = 1'b1; start_addr = 10'h058;
        cycle("rst_start");
        start = 1'b0;
        cycle("rst_run1");
        cycle("rst_run2");
        total++;
        if (prog_ctr !== 10'h05A) begin
            bad++; $display("FAIL reset_pre_pc: got %h want 05a", prog_ctr);
        end
        rst = 1'b1;
        cycle("rst_mid1");
        cycle("rst_mid2");
        total++;
        if (prog_ctr !== 10'h0 || inst !== 9'h0 || inst_valid !== 1'b0 || running !== 1'b0 ||
            done !== 1'b0 || fetch_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_zero: got pc=%h inst=%h v=%b r=%b d=%b c=%0d want all 0",
                            prog_ctr, inst, inst_valid, running, done, fetch_cnt);
        end
        rst = 1'b0;
        cycle("rst_idle1");
        cycle("rst_idle2");
        total++;
        if (running !== 1'b0 || prog_ctr !== 10'h0) begin
            bad++; $display("FAIL reset_needs_start: got run=%b pc=%h want 0/000", running, prog_ctr);
        end
    endtask

    task automatic test_start();
        logic [8:0] exp_i [3];
        exp_i[0] = 9'h1A1; exp_i[1] = 9'h0F3; exp_i[2] = 9'h155;
        clear_inputs();
        start = 1'b1; start_addr = 10'h010;
        cycle("start");
        start = 1'b0;
        total++;
        if (prog_ctr !== 10'h010 || inst_valid !== 1'b0 || running !== 1'b1) begin
            bad++; $display("FAIL start_entry: got pc=%h v=%b r=%b want 010/0/1",
                            prog_ctr, inst_valid, running);
        end
        for (int i = 0; i < 3; i++) begin
            cycle("seq");
            total++;
            if (inst !== exp_i[i] || prog_ctr !== 10'(10'h011 + i) || inst_valid !== 1'b1) begin
                bad++; $display("FAIL seq_%0d: got inst=%h pc=%h v=%b want inst=%h pc=%h v=1",
                                i, inst, prog_ctr, inst_valid, exp_i[i], 10'(10'h011 + i));
            end
        end
        total++;
        if (fetch_cnt !== 16'd3) begin
            bad++; $display("FAIL seq_cnt: got %0d want 3", fetch_cnt);
        end
    endtask

    task automatic test_wrap();
        clear_inputs();
        br_abs = 1'b1; target = 10'h3FE;
        cycle("wrap_jump");
        clear_inputs();
        cycle("wrap_3ff");
        cycle("wrap_000");
        total++;
        if (prog_ctr !== 10'h000) begin
            bad++; $display("FAIL wrap_inc: got %h want 000", prog_ctr);
        end
        cycle("wrap_001");
        br_rel = 1'b1; taken = 1'b1; offset = 6'h3E;
        cycle("wrap_rel");
        total++;
        if (prog_ctr !== 10'h3FF || inst_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_rel: got pc=%h v=%b want 3ff/0", prog_ctr, inst_valid);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        clear_inputs();
        br_abs = 1'b1; target = 10'h020;
        cycle("br_to20");
        clear_inputs();
        br_rel = 1'b1; taken = 1'b1; offset = 6'd5;
        cycle("br_rel_t");
        total++;
        if (prog_ctr !== 10'h025 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL rel_taken: got pc=%h v=%b want 025/0", prog_ctr, inst_valid);
        end
        clear_inputs();
        cycle("br_after");
        total++;
        if (prog_ctr !== 10'h026 || inst_valid !== 1'b1) begin
            bad++; $display("FAIL rel_bubble: got pc=%h v=%b want 026/1", prog_ctr, inst_valid);
        end
        br_abs = 1'b1; target = 10'h020;
        cycle("br_to20b");
        clear_inputs();
        br_rel = 1'b1; taken = 1'b0; offset = 6'd5;
        start = 1'b1; start_addr = 10'h300;
        cycle("br_rel_nt");
        total++;
        if (prog_ctr !== 10'h021 || inst_valid !== 1'b1) begin
            bad++; $display("FAIL rel_not_taken: got pc=%h v=%b want 021/1", prog_ctr, inst_valid);
        end
        clear_inputs();
        br_abs = 1'b1; target = 10'h100; br_rel = 1'b1; taken = 1'b1; offset = 6'd5;
        cycle("br_abs_pri");
        total++;
        if (prog_ctr !== 10'h100) begin
            bad++; $display("FAIL abs_priority: got %h want 100", prog_ctr);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        logic [15:0] cnt_hold;
        clear_inputs();
        cycle("st_pre");
        cnt_hold = m_cnt;
        stall = 1'b1; br_abs = 1'b1; target = 10'h200;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            total++;
            if (prog_ctr !== 10'h101 || inst !== rom_mem[10'h100] || fetch_cnt !== cnt_hold) begin
                bad++; $display("FAIL stall_hold_%0d: got pc=%h inst=%h cnt=%0d want 101/%h/%0d",
                                i, prog_ctr, inst, fetch_cnt, rom_mem[10'h100], cnt_hold);
            end
        end
        stall = 1'b0;
        cycle("st_release");
        total++;
        if (prog_ctr !== 10'h200 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release: got pc=%h v=%b want 200/0", prog_ctr, inst_valid);
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        clear_inputs();
        br_abs = 1'b1; target = 10'h044;
        cycle("h_to44");
        clear_inputs();
        halt = 1'b1; stall = 1'b1;
        cycle("halt");
        total++;
        if (done !== 1'b1 || running !== 1'b0 || prog_ctr !== 10'h044 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL halt: got d=%b r=%b pc=%h v=%b want 1/0/044/0",
                            done, running, prog_ctr, inst_valid);
        end
        stall = 1'b0;
        cycle("halt_hold");
        clear_inputs();
        start = 1'b1; start_addr = 10'h000;
        cycle("restart");
        start = 1'b0;
        total++;
        if (running !== 1'b1 || done !== 1'b0 || fetch_cnt !== 16'd0 || prog_ctr !== 10'h000) begin
            bad++; $display("FAIL restart: got r=%b d=%b cnt=%0d pc=%h want 1/0/0/000",
                            running, done, fetch_cnt, prog_ctr);
        end
        cycle("restart1");
        cycle("restart2");
        total++;
        if (fetch_cnt !== 16'd2 || prog_ctr !== 10'h002) begin
            bad++; $display("FAIL restart_count: got cnt=%0d pc=%h want 2/002", fetch_cnt, prog_ctr);
        end
        rst = 1'b1;
        cycle("h_rst");
        rst = 1'b0; halt = 1'b1;
        cycle("halt_idle");
        total++;
        if (done !== 1'b0 || running !== 1'b0 || prog_ctr !== 10'h000) begin
            bad++; $display("FAIL halt_idle: got d=%b r=%b pc=%h want 0/0/000", done, running, prog_ctr);
        end
        clear_inputs();
    endtask

    task automatic test_saturate();
        clear_inputs();
        rst = 1'b1;
        cycle("sat_rst");
        rst = 1'b0; start = 1'b1; start_addr = 10'h010;
        cycle("sat_start");
        start = 1'b0;
        for (int i = 0; i < 10; i++) cycle("sat_run");
        total++;
        if (sat_cnt !== 3'd7 || sat_running !== 1'b1) begin
            bad++; $display("FAIL cnt_saturate: got %0d run=%b want 7/1", sat_cnt, sat_running);
        end
        total++;
        if (fetch_cnt !== 16'd10) begin
            bad++; $display("FAIL cnt_wide: got %0d want 10", fetch_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 9'((i * 37 + 11) ^ (i >> 3));
        rom_mem[10'h010] = 9'h1A1;
        rom_mem[10'h011] = 9'h0F3;
        rom_mem[10'h012] = 9'h155;
        clear_inputs();
        test_reset();
        test_start();
        test_wrap();
        test_branch();
        test_stall();
        test_halt();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
